// File: rtl/cpu_phase_sequencer.sv
// Multicycle phase sequencer: steps each instruction through FETCH/READ/MEM/WB with
// ready-stall handshakes, per-instruction phase skipping, a stall timeout and a retire counter.
module cpu_phase_sequencer #(
    parameter int unsigned          PC_WIDTH     = 32,
    parameter logic [PC_WIDTH-1:0]  RESET_PC     = '0,
    parameter int unsigned          WAIT_TIMEOUT = 16,
    parameter int unsigned          CNT_WIDTH    = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 run_i,
    input  logic [PC_WIDTH-1:0]  pc_next_i,
    input  logic                 skip_mem_i,
    input  logic                 skip_wb_i,
    input  logic                 imem_ready_i,
    input  logic                 dmem_ready_i,
    output logic [PC_WIDTH-1:0]  pc_o,
    output logic                 fetch_en_o,
    output logic                 read_en_o,
    output logic                 mem_en_o,
    output logic                 write_en_o,
    output logic [2:0]           phase_o,
    output logic                 instr_done_o,
    output logic [CNT_WIDTH-1:0] retire_count_o,
    output logic                 fault_o
);

    localparam int unsigned     WaitW     = (WAIT_TIMEOUT > 1) ? $clog2(WAIT_TIMEOUT) : 1;
    localparam bit              TimeoutEn = (WAIT_TIMEOUT != 0);
    localparam logic [WaitW-1:0] WaitLast =
        (WAIT_TIMEOUT > 0) ? WaitW'(WAIT_TIMEOUT - 1) : '0;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StFetch = 3'd1,
        StRead  = 3'd2,
        StMem   = 3'd3,
        StWb    = 3'd4,
        StFault = 3'd7
    } state_e;

    state_e               state_q, state_d;
    logic [WaitW-1:0]     wait_q, wait_d;
    logic                 skip_wb_q, skip_wb_d;
    logic [PC_WIDTH-1:0]  pc_q, pc_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 done_q;
    logic                 retire;
    logic                 stall;

    always_comb begin
        state_d   = state_q;
        wait_d    = '0;
        skip_wb_d = skip_wb_q;
        retire    = 1'b0;
        stall     = 1'b0;

        unique case (state_q)
            StIdle:  if (run_i) state_d = StFetch;
            StFetch: begin
                if (imem_ready_i) state_d = StRead;
                else              stall   = 1'b1;
            end
            StRead: begin
                skip_wb_d = skip_wb_i;
                if (!skip_mem_i)     state_d = StMem;
                else if (!skip_wb_i) state_d = StWb;
                else                 retire  = 1'b1;
            end
            StMem: begin
                if (dmem_ready_i) begin
                    if (!skip_wb_q) state_d = StWb;
                    else            retire  = 1'b1;
                end else begin
                    stall = 1'b1;
                end
            end
            StWb:    retire = 1'b1;
            StFault: state_d = StFault;
            default: state_d = StFault;
        endcase

        // Counter only runs while stalled; any state change clears it for the next wait phase.
        if (stall && TimeoutEn) begin
            if (wait_q == WaitLast) state_d = StFault;
            else                    wait_d  = wait_q + 1'b1;
        end

        if (retire) state_d = run_i ? StFetch : StIdle;

        pc_d  = retire ? pc_next_i : pc_q;
        cnt_d = retire ? cnt_q + 1'b1 : cnt_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            wait_q    <= '0;
            skip_wb_q <= 1'b0;
            pc_q      <= RESET_PC;
            cnt_q     <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            skip_wb_q <= skip_wb_d;
            pc_q      <= pc_d;
            cnt_q     <= cnt_d;
            done_q    <= retire;
        end
    end

    assign pc_o           = pc_q;
    assign phase_o        = state_q;
    assign fetch_en_o     = (state_q == StFetch);
    assign read_en_o      = (state_q == StRead);
    assign mem_en_o       = (state_q == StMem);
    assign write_en_o     = (state_q == StWb);
    assign fault_o        = (state_q == StFault);
    assign instr_done_o   = done_q;
    assign retire_count_o = cnt_q;

endmodule

// File: tb/tb_cpu_phase_sequencer.sv
// Scoreboarded bench for cpu_phase_sequencer: directed instructions push expected retire
// results; a monitor pops and compares them whenever instr_done is seen.
module tb_cpu_phase_sequencer;

    localparam int unsigned CW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          run = 1'b0;
    logic [31:0]   pc_next = 32'hDEAD_BEEF;
    logic          skip_mem = 1'b0;
    logic          skip_wb = 1'b0;
    logic          imem_ready = 1'b0;
    logic          dmem_ready = 1'b0;
    logic [31:0]   pc_o;
    logic          fetch_en_o, read_en_o, mem_en_o, write_en_o;
    logic [2:0]    phase_o;
    logic          instr_done_o;
    logic [CW-1:0] retire_count_o;
    logic          fault_o;

    cpu_phase_sequencer #(
        .PC_WIDTH    (32),
        .RESET_PC    (32'h0),
        .WAIT_TIMEOUT(4),
        .CNT_WIDTH   (CW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .run_i         (run),
        .pc_next_i     (pc_next),
        .skip_mem_i    (skip_mem),
        .skip_wb_i     (skip_wb),
        .imem_ready_i  (imem_ready),
        .dmem_ready_i  (dmem_ready),
        .pc_o          (pc_o),
        .fetch_en_o    (fetch_en_o),
        .read_en_o     (read_en_o),
        .mem_en_o      (mem_en_o),
        .write_en_o    (write_en_o),
        .phase_o       (phase_o),
        .instr_done_o  (instr_done_o),
        .retire_count_o(retire_count_o),
        .fault_o       (fault_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0]   pc;
        logic [CW-1:0] cnt;
    } exp_t;

    exp_t        exp_q[$];
    int          n_checks = 0;
    int          n_fail = 0;
    logic [31:0] cur_pc = 32'h0;
    int          exp_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every retirement must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && instr_done_o) begin
            if (exp_q.size() == 0) begin
                check("unexpected instr_done", 32'(instr_done_o), 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("retire pc", pc_o, e.pc);
                check("retire count", 32'(retire_count_o), 32'(e.cnt));
            end
        end
    end

    // Runs one instruction starting in FETCH; drives readies/skips per observed phase and
    // keeps skip flags and pc_next at decoy values outside their sample points.
    task automatic do_instr(input bit sm, input bit sw, input int iw, input int dw,
                            input logic [31:0] npc, input bit drop);
        int   nf = 0, nm = 0, cyc = 0;
        int   ef = 0, er = 0, em = 0, ew = 0;
        bit   seen_read = 0, done = 0;
        exp_t e;
        exp_cnt++;
        e.pc  = npc;
        e.cnt = CW'(exp_cnt);
        exp_q.push_back(e);
        for (int k = 0; k < 40 && !done; k++) begin
            if (seen_read && (phase_o == 3'd1 || phase_o == 3'd0)) begin
                done = 1;
            end else begin
                imem_ready = 1'b0;
                dmem_ready = 1'b0;
                skip_mem   = ~sm;
                skip_wb    = ~sw;
                pc_next    = 32'hDEAD_BEEF;
                cyc++;
                ef += int'(fetch_en_o);
                er += int'(read_en_o);
                em += int'(mem_en_o);
                ew += int'(write_en_o);
                case (phase_o)
                    3'd1: begin
                        imem_ready = (nf >= iw);
                        nf++;
                    end
                    3'd2: begin
                        seen_read = 1;
                        skip_mem  = sm;
                        skip_wb   = sw;
                        check("pc held", pc_o, cur_pc);
                        if (sm && sw) pc_next = npc;
                    end
                    3'd3: begin
                        dmem_ready = (nm >= dw);
                        nm++;
                        if (drop) run = 1'b0;
                        if (dmem_ready && sw) pc_next = npc;
                    end
                    3'd4: pc_next = npc;
                    default: ;
                endcase
                tick();
            end
        end
        check("instr completes", 32'(done), 32'd1);
        check("fetch cycles", 32'(ef), 32'(iw + 1));
        check("read cycles", 32'(er), 32'd1);
        check("mem cycles", 32'(em), sm ? 32'd0 : 32'(dw + 1));
        check("wb cycles", 32'(ew), sw ? 32'd0 : 32'd1);
        check("instr cycles", 32'(cyc),
              32'((iw + 1) + 1 + (sm ? 0 : dw + 1) + (sw ? 0 : 1)));
        check("next phase", 32'(phase_o), drop ? 32'd0 : 32'd1);
        cur_pc = npc;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        run = 1'b1;
        tick();
        check("reset phase", 32'(phase_o), 32'd0);
        check("reset pc", pc_o, 32'd0);
        check("reset enables", 32'({fetch_en_o, read_en_o, mem_en_o, write_en_o}), 32'd0);
        check("reset instr_done", 32'(instr_done_o), 32'd0);
        check("reset retire_count", 32'(retire_count_o), 32'd0);
        check("reset fault", 32'(fault_o), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        check("first fetch", 32'(phase_o), 32'd1);

        do_instr(0, 0, 0, 0, 32'd4, 0);
        do_instr(0, 0, 0, 0, 32'd8, 0);
        do_instr(0, 0, 0, 0, 32'd12, 0);
        do_instr(1, 1, 0, 0, 32'd16, 0);
        do_instr(1, 0, 0, 0, 32'd20, 0);
        do_instr(0, 1, 0, 0, 32'd24, 0);
        do_instr(0, 0, 3, 2, 32'd28, 0);
        check("no fault after waits", 32'(fault_o), 32'd0);
        do_instr(0, 0, 0, 3, 32'd32, 0);
        check("no fault ready on last cycle", 32'(fault_o), 32'd0);

        do_instr(0, 0, 0, 0, 32'd36, 1);
        tick();
        tick();
        check("idle holds", 32'(phase_o), 32'd0);
        run = 1'b1;
        tick();
        check("fetch after run", 32'(phase_o), 32'd1);

        // Enough short instructions to carry the 4-bit counter through 15 -> 0.
        for (int i = 0; i < 10; i++) do_instr(1, 1, 0, 0, 32'(40 + 4 * i), 0);

        // Stall timeout in MEM.
        imem_ready = 1'b1;
        check("fault seq fetch", 32'(phase_o), 32'd1);
        tick();
        imem_ready = 1'b0;
        skip_mem   = 1'b0;
        skip_wb    = 1'b0;
        pc_next    = 32'hDEAD_BEEF;
        check("fault seq read", 32'(phase_o), 32'd2);
        tick();
        for (int i = 0; i < 4; i++) begin
            dmem_ready = 1'b0;
            check("mem stall", 32'(phase_o), 32'd3);
            tick();
        end
        check("fault phase", 32'(phase_o), 32'd7);
        check("fault flag", 32'(fault_o), 32'd1);
        check("fault enables", 32'({fetch_en_o, read_en_o, mem_en_o, write_en_o}), 32'd0);
        check("fault pc frozen", pc_o, cur_pc);
        check("fault count frozen", 32'(retire_count_o), 32'(exp_cnt % 16));
        dmem_ready = 1'b1;
        imem_ready = 1'b1;
        tick();
        tick();
        tick();
        check("fault sticky", 32'(phase_o), 32'd7);
        check("fault pc still", pc_o, cur_pc);

        // Asynchronous reset in the middle of MEM.
        #2 rst = 1'b1;
        tick();
        rst        = 1'b0;
        exp_cnt    = 0;
        cur_pc     = 32'h0;
        imem_ready = 1'b0;
        dmem_ready = 1'b0;
        tick();
        check("fetch after fault reset", 32'(phase_o), 32'd1);
        imem_ready = 1'b1;
        tick();
        imem_ready = 1'b0;
        tick();
        check("in mem before reset", 32'(phase_o), 32'd3);
        pc_next = 32'h0000_5555;
        #2 rst = 1'b1;
        #1;
        check("async reset phase", 32'(phase_o), 32'd0);
        check("async reset pc", pc_o, 32'd0);
        check("async reset mem_en", 32'(mem_en_o), 32'd0);
        check("async reset count", 32'(retire_count_o), 32'd0);
        check("async reset fault", 32'(fault_o), 32'd0);
        check("async reset done", 32'(instr_done_o), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        check("fetch after async reset", 32'(phase_o), 32'd1);
        do_instr(0, 0, 0, 0, 32'h100, 0);
        tick();
        tick();
        check("scoreboard drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cpu_phase_sequencer.md
# cpu_phase_sequencer

Parametrised multicycle control sequencer for the CPU datapath: steps each instruction through FETCH, READ, MEM and WB phases and drives one-hot phase enables to instruction memory, decoder, register file and data memory. Successor to the fixed 4-count phase counter, it adds:
- memory-ready stall handshakes
- per-instruction phase skipping
- a run/idle control
- a stall-timeout fault
- a retired-instruction counter

It owns the PC register and loads it from the next-PC logic at retirement.

## Interface
- PC_WIDTH, 32, width of PC and next-PC.
- RESET_PC, 0, PC value after reset.
- WAIT_TIMEOUT, 16, maximum consecutive not-ready cycles in FETCH or MEM before fault; 0 disables the timeout.
- CNT_WIDTH, 16, width of the retire counter.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- run  in  1  1 = keep issuing instructions; 0 = go idle after the current instruction retires.
- pc_next  in  PC_WIDTH  next PC from next-PC logic; loaded at retire.
- skip_mem  in  1  decoder flag; instruction needs no MEM phase; sampled in READ.
- skip_wb  in  1  decoder flag; instruction needs no WB phase; sampled in READ.
- imem_ready  in  1  instruction memory done; ends FETCH.
- dmem_ready  in  1  data memory done; ends MEM.
- pc  out  PC_WIDTH  current PC.
- fetch_en  out  1  high throughout FETCH.
- read_en  out  1  high throughout READ.
- mem_en  out  1  high throughout MEM.
- write_en  out  1  high throughout WB.
- phase  out  3  IDLE=0, FETCH=1, READ=2, MEM=3, WB=4, FAULT=7.
- instr_done  out  1  one-cycle pulse, the cycle after a retire edge.
- retire_count  out  CNT_WIDTH  retired instructions, wraps modulo 2^CNT_WIDTH.
- fault  out  1  sticky stall-timeout indication.

## Operation
- Moore FSM: IDLE, FETCH, READ, MEM, WB, FAULT. Enables and phase decode only the current state; at most one enable high; all enables low in IDLE/FAULT.
- IDLE: run=1 -> FETCH; else stay.
- FETCH:
  - imem_ready=1 -> READ.
  - Else stay and increment wait counter.
- READ: exactly one cycle; registers skip_mem/skip_wb.
  - Next is MEM if skip_mem=0.
  - Else WB if skip_wb=0.
  - Else retire.
- MEM:
  - dmem_ready=1 -> WB if skip_wb=0, else retire.
  - Else stay and increment wait counter.
- WB: exactly one cycle, then retire.
- Retire (transition edge, not a state):
  - pc <= pc_next; retire_count += 1; instr_done=1 next cycle.
  - Next state FETCH if run=1, else IDLE.
- Wait counter: cleared on entry to FETCH and MEM. Not-ready cycle while counter = WAIT_TIMEOUT-1 (WAIT_TIMEOUT≠0) -> FAULT.
  - ready=1 on that same cycle wins: normal advance, no fault.
- FAULT: fault=1, enables 0, pc and retire_count frozen. Exit only via rst.
- run=0 mid-instruction: instruction completes normally, then IDLE. run is only sampled in IDLE and at retire.
- skip flags and pc_next outside their sample points are ignored.

## Timing
- Reset (async assert, any state, mid-instruction included):
  - state IDLE, pc=RESET_PC, all enables 0, phase=0.
  - instr_done=0, retire_count=0, fault=0, wait counter 0.
  - An interrupted instruction does not retire.
- First FETCH begins the cycle after the first edge with rst=0 and run=1.
- Cycles per instruction with zero waits:
  - 4 (F,R,M,W) with no skips.
  - 3 with one skip.
  - 2 (F,R) with both skips.
  - Each ready-low cycle adds 1.
- Back-to-back with run=1: next FETCH is the cycle immediately after the retiring phase; no bubble.
- pc changes on the retire edge; the new pc is visible in the same cycle as the next fetch_en and instr_done.
- Timeout: with WAIT_TIMEOUT=N and ready held low, fault rises after N cycles of FETCH (or MEM).
- retire_count wraps all-ones -> 0 without fault.

## Test plan
- Reset then run=1, readies tied high, skips 0, pc_next=pc+4:
  - enables cycle F,R,M,W repeatedly.
  - pc 0->4->8 every 4 cycles; instr_done every 4th cycle.
- skip_mem=1, skip_wb=1 in READ:
  - FETCH/READ only, 2-cycle instruction.
  - skip_mem=1 alone: F,R,W.
  - skip_wb=1 alone: F,R,M.
- imem_ready low 3 cycles, dmem_ready low 2 cycles:
  - instruction takes 9 cycles; fetch_en held 4 cycles, mem_en held 3.
  - no fault with WAIT_TIMEOUT=16.
- WAIT_TIMEOUT=4, dmem_ready held low:
  - FAULT after 4 MEM cycles; phase=7, enables 0, pc frozen.
  - Repeat with ready rising exactly in the 4th cycle: WB, no fault.
- run dropped during MEM: instruction finishes (WB, pc loaded, instr_done), then IDLE.
  - run raised again: FETCH next cycle.
- rst asserted mid-MEM (asynchronous, between edges):
  - outputs immediately at reset values, retire_count=0.
  - CNT_WIDTH=4 run: retire_count wraps 15->0.
